// File: rtl/dht11_sensor_emulator.sv
// DHT11 sensor-side responder: waits for a host start pulse on the open-drain line,
// then answers with the response preamble and a 40-bit humidity/temperature frame.
module dht11_sensor_emulator #(
    parameter int CLK_PER_US    = 1,
    parameter int START_MIN_US  = 18000,
    parameter int RESP_DELAY_US = 30,
    parameter int PREAMBLE_US   = 80,
    parameter int BIT_LOW_US    = 50,
    parameter int BIT0_HIGH_US  = 27,
    parameter int BIT1_HIGH_US  = 70
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] humidity_int,
    input  logic [7:0] humidity_dec,
    input  logic [7:0] temperature_int,
    input  logic [7:0] temperature_dec,
    input  logic       inject_checksum_error,
    inout  wire        transmission_line,
    output logic       busy,
    output logic       frame_done,
    output logic [3:0] debug_state
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_HOST_LOW  = 4'd1,
        S_WAIT      = 4'd2,
        S_RESP_LOW  = 4'd3,
        S_RESP_HIGH = 4'd4,
        S_BIT_LOW   = 4'd5,
        S_BIT_HIGH  = 4'd6,
        S_END_LOW   = 4'd7
    } state_t;

    localparam int PRE_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_US - 1);
    localparam logic [14:0] START_MIN = 15'(START_MIN_US);
    localparam logic [14:0] RESP_DLY  = 15'(RESP_DELAY_US);
    localparam logic [14:0] PREAMBLE  = 15'(PREAMBLE_US);
    localparam logic [14:0] BIT_LOW   = 15'(BIT_LOW_US);
    localparam logic [14:0] BIT0_HIGH = 15'(BIT0_HIGH_US);
    localparam logic [14:0] BIT1_HIGH = 15'(BIT1_HIGH_US);

    state_t           state;
    state_t           state_next;
    logic [PRE_W-1:0] pre_cnt;
    logic             tick;
    logic [14:0]      us_cnt;
    logic [14:0]      phase_dur;
    logic             phase_done;
    logic             line_meta;
    logic             line_sync;
    logic             line_prev;
    logic             line_rise;
    logic             line_fall;
    logic             armed;
    logic             host_ok;
    logic             accept;
    logic [5:0]       bit_idx;
    logic [39:0]      frame;
    logic [9:0]       sum10;
    logic [7:0]       checksum;
    logic             drive_low;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            line_meta <= 1'b0;
            line_sync <= 1'b0;
            line_prev <= 1'b0;
            armed     <= 1'b0;
        end else begin
            line_meta <= transmission_line;
            line_sync <= line_meta;
            line_prev <= line_sync;
            armed     <= armed | line_sync;
        end
    end

    assign line_rise = line_sync & ~line_prev;
    assign line_fall = ~line_sync & line_prev;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            pre_cnt <= '0;
        else if (pre_cnt == PRE_LAST)
            pre_cnt <= '0;
        else
            pre_cnt <= pre_cnt + 1'b1;
    end

    assign tick = (pre_cnt == PRE_LAST);

    // Phase counter restarts on every state change; saturates while timing the host pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            us_cnt <= '0;
        else if (state_next != state)
            us_cnt <= '0;
        else if (tick && state != S_IDLE) begin
            if (state != S_HOST_LOW || us_cnt < START_MIN)
                us_cnt <= us_cnt + 1'b1;
        end
    end

    always_comb begin
        phase_dur = '0;
        case (state)
            S_WAIT:                 phase_dur = RESP_DLY;
            S_RESP_LOW, S_RESP_HIGH: phase_dur = PREAMBLE;
            S_BIT_LOW, S_END_LOW:   phase_dur = BIT_LOW;
            S_BIT_HIGH:             phase_dur = frame[bit_idx] ? BIT1_HIGH : BIT0_HIGH;
            default:                phase_dur = '0;
        endcase
    end

    assign phase_done = tick && (us_cnt == phase_dur - 15'd1);

    // The cycle in which the falling edge was detected is not counted, hence the -1.
    assign host_ok  = (us_cnt >= START_MIN - 15'd1);
    assign accept   = (state == S_HOST_LOW) && line_rise && host_ok;
    assign sum10    = {2'b00, humidity_int} + {2'b00, humidity_dec}
                    + {2'b00, temperature_int} + {2'b00, temperature_dec};
    assign checksum = sum10[7:0] + {7'd0, inject_checksum_error};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            frame <= '0;
        else if (accept)
            frame <= {humidity_int, humidity_dec, temperature_int, temperature_dec, checksum};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            bit_idx <= '0;
        else if (state == S_RESP_HIGH && phase_done)
            bit_idx <= 6'd39;
        else if (state == S_BIT_HIGH && phase_done && bit_idx != 6'd0)
            bit_idx <= bit_idx - 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      if (armed && line_fall) state_next = S_HOST_LOW;
            S_HOST_LOW:  if (line_rise) state_next = host_ok ? S_WAIT : S_IDLE;
            S_WAIT:      if (phase_done) state_next = S_RESP_LOW;
            S_RESP_LOW:  if (phase_done) state_next = S_RESP_HIGH;
            S_RESP_HIGH: if (phase_done) state_next = S_BIT_LOW;
            S_BIT_LOW:   if (phase_done) state_next = S_BIT_HIGH;
            S_BIT_HIGH:  if (phase_done) state_next = (bit_idx == 6'd0) ? S_END_LOW : S_BIT_LOW;
            S_END_LOW:   if (phase_done) state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    always_comb begin
        drive_low = 1'b0;
        busy      = 1'b0;
        case (state)
            S_WAIT, S_RESP_HIGH, S_BIT_HIGH: busy = 1'b1;
            S_RESP_LOW, S_BIT_LOW, S_END_LOW: begin
                busy      = 1'b1;
                drive_low = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            frame_done <= 1'b0;
        else
            frame_done <= (state == S_END_LOW) && phase_done;
    end

    // Open drain: the line is only ever pulled low, the pull-up supplies the high level.
    assign transmission_line = drive_low ? 1'b0 : 1'bz;
    assign debug_state       = state;

endmodule

// File: tb/tb_dht11_sensor_emulator.sv
// Bench for dht11_sensor_emulator: plays the host on a pulled-up line, decodes the
// reply by pulse widths and compares each frame against a byte-level model.
module tb_dht11_sensor_emulator;

    localparam int START_MIN = 1800;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] hi = 8'h00;
    logic [7:0] hd = 8'h00;
    logic [7:0] ti = 8'h00;
    logic [7:0] td = 8'h00;
    logic       inj = 1'b0;
    logic       host_low = 1'b0;
    wire        line;
    logic       busy;
    logic       frame_done;
    logic [3:0] debug_state;

    int          n_checks = 0;
    int          n_fail = 0;
    int          done_count = 0;
    int          bits_rx = 0;
    bit          busy_ok;
    logic [39:0] exp_q[$];

    pullup (line);
    assign line = host_low ? 1'b0 : 1'bz;

    dht11_sensor_emulator #(.START_MIN_US(START_MIN)) dut (
        .clock                 (clock),
        .reset_n               (reset_n),
        .humidity_int          (hi),
        .humidity_dec          (hd),
        .temperature_int       (ti),
        .temperature_dec       (td),
        .inject_checksum_error (inj),
        .transmission_line     (line),
        .busy                  (busy),
        .frame_done            (frame_done),
        .debug_state           (debug_state)
    );

    // clock / reset
    always #5 clock = ~clock;

    always @(negedge clock) if (frame_done === 1'b1) done_count++;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] frame_model(input int h_i, input int h_d, input int t_i,
                                                input int t_d, input int err);
        int cs;
        cs = (h_i + h_d + t_i + t_d + err) % 256;
        return {8'(h_i), 8'(h_d), 8'(t_i), 8'(t_d), 8'(cs)};
    endfunction

    // driver tasks
    task automatic host_start(input int low_us);
        @(posedge clock);
        #1 host_low = 1'b1;
        repeat (low_us) @(posedge clock);
        #1 host_low = 1'b0;
    endtask

    task automatic measure(input logic level, output int len);
        len = 1;
        if (busy !== 1'b1) busy_ok = 1'b0;
        while (1) begin
            @(negedge clock);
            if (line !== level || len >= 400) break;
            if (busy !== 1'b1) busy_ok = 1'b0;
            len++;
        end
    endtask

    task automatic receive_frame(output logic [39:0] data, output bit timing_ok, output bit ok);
        int t;
        int lo;
        int hl;
        data = '0;
        ok = 1'b1;
        timing_ok = 1'b1;
        bits_rx = 0;
        busy_ok = 1'b1;
        t = 0;
        while (1) begin
            @(negedge clock);
            if (line !== 1'b1 || t >= 200) break;
            t++;
        end
        if (t >= 200) begin
            ok = 1'b0;
            return;
        end
        if (t < 27 || t > 33) timing_ok = 1'b0;
        measure(1'b0, lo);
        if (lo < 79 || lo > 81) timing_ok = 1'b0;
        measure(1'b1, hl);
        if (hl < 79 || hl > 81) timing_ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            measure(1'b0, lo);
            measure(1'b1, hl);
            if (lo >= 400 || hl >= 400) begin
                ok = 1'b0;
                return;
            end
            if (lo < 49 || lo > 51) timing_ok = 1'b0;
            if (hl > 48) begin
                data = {data[38:0], 1'b1};
                if (hl < 69 || hl > 71) timing_ok = 1'b0;
            end else begin
                data = {data[38:0], 1'b0};
                if (hl < 26 || hl > 28) timing_ok = 1'b0;
            end
            bits_rx++;
        end
        measure(1'b0, lo);
        if (lo < 49 || lo > 51) timing_ok = 1'b0;
    endtask

    // scoreboard-driven frame: push expectation, start, decode, compare
    task automatic run_valid_frame(input string tag, input int low_len);
        logic [39:0] got;
        bit          t_ok;
        bit          ok;
        int          d0;
        exp_q.push_back(frame_model(hi, hd, ti, td, inj));
        d0 = done_count;
        host_start(low_len);
        receive_frame(got, t_ok, ok);
        repeat (5) @(negedge clock);
        check_eq({tag, "_complete"}, 64'(ok), 64'd1);
        check_eq({tag, "_data"}, 64'(got), 64'(exp_q.pop_front()));
        check_eq({tag, "_timing"}, 64'(t_ok), 64'd1);
        check_eq({tag, "_busy_during"}, 64'(busy_ok), 64'd1);
        check_eq({tag, "_frame_done_count"}, 64'(done_count - d0), 64'd1);
        check_eq({tag, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    task automatic check_silence(input string tag);
        bit line_low_seen;
        bit busy_seen;
        int d0;
        line_low_seen = 1'b0;
        busy_seen = 1'b0;
        d0 = done_count;
        repeat (300) begin
            @(negedge clock);
            if (line !== 1'b1) line_low_seen = 1'b1;
            if (busy !== 1'b0) busy_seen = 1'b1;
        end
        check_eq({tag, "_line_idle"}, 64'(line_low_seen), 64'd0);
        check_eq({tag, "_busy_idle"}, 64'(busy_seen), 64'd0);
        check_eq({tag, "_no_frame_done"}, 64'(done_count - d0), 64'd0);
    endtask

    initial begin
        int falls;
        int d0;
        logic prev;

        repeat (3) @(negedge clock);
        check_eq("reset_line", 64'(line), 64'd1);
        check_eq("reset_busy", 64'(busy), 64'd0);
        check_eq("reset_frame_done", 64'(frame_done), 64'd0);
        check_eq("reset_state", 64'(debug_state), 64'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (10) @(posedge clock);

        hi = 8'h37; hd = 8'h00; ti = 8'h19; td = 8'h00; inj = 1'b0;
        check_eq("model_s1", 64'(frame_model(hi, hd, ti, td, inj)), 64'h3700190050);
        run_valid_frame("s1", START_MIN);

        host_start(START_MIN - 800);
        check_silence("s2_short");

        inj = 1'b1;
        run_valid_frame("s3_cs_err", START_MIN + 50);
        inj = 1'b0;

        hi = 8'hFF; hd = 8'hFF; ti = 8'h01; td = 8'h02;
        bits_rx = 0;
        fork
            run_valid_frame("s4_wrap", START_MIN + 10);
            begin
                for (int k = 0; k < 20000 && bits_rx < 20; k++) @(negedge clock);
                ti = 8'h40;
            end
        join

        hi = 8'h2A; hd = 8'h05; ti = 8'h17; td = 8'h09;
        host_start(START_MIN);
        falls = 0;
        prev = 1'b1;
        for (int k = 0; k < 20000 && falls < 14; k++) begin
            @(negedge clock);
            if (prev === 1'b1 && line === 1'b0) falls++;
            prev = line;
        end
        check_eq("s5_reached_bit12", 64'(falls), 64'd14);
        repeat (10) @(negedge clock);
        check_eq("s5_low_before_reset", 64'(line), 64'd0);
        d0 = done_count;
        reset_n = 1'b0;
        #1;
        check_eq("s5_line_released", 64'(line), 64'd1);
        check_eq("s5_busy_cleared", 64'(busy), 64'd0);
        repeat (5) @(negedge clock);
        reset_n = 1'b1;
        repeat (300) @(negedge clock);
        check_eq("s5_no_frame_done", 64'(done_count - d0), 64'd0);
        run_valid_frame("s5_after", START_MIN);

        host_low = 1'b1;
        @(negedge clock);
        reset_n = 1'b0;
        repeat (5) @(negedge clock);
        reset_n = 1'b1;
        repeat (2000) @(posedge clock);
        #1 host_low = 1'b0;
        check_silence("s6_unarmed");
        run_valid_frame("s6_next", START_MIN + 5);

        for (int r = 0; r < 4; r++) begin
            hi  = 8'($urandom_range(0, 255));
            hd  = 8'($urandom_range(0, 255));
            ti  = 8'($urandom_range(0, 255));
            td  = 8'($urandom_range(0, 255));
            inj = 1'($urandom_range(0, 1));
            repeat ($urandom_range(10, 100)) @(posedge clock);
            run_valid_frame($sformatf("rand%0d", r), $urandom_range(START_MIN, START_MIN + 400));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
